// File: rtl/uart_char_source.sv
// Serial character receiver feeding the scrolling display: 8N1 frames (8E1 when
// UART_PARITY_EN is defined) become an ascii byte with a dsn strobe, or a clearn strobe.
module uart_char_source #(
    parameter int         CLKS_PER_BIT  = 278,
    parameter int         STROBE_CYCLES = 16,
    parameter logic [7:0] CLEAR_CHAR    = 8'h0C
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] ascii,
    output logic       dsn,
    output logic       clearn,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    localparam int            CW          = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

`ifdef UART_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    logic [1:0]    sync_reg;
    logic          rx_s;
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    data_reg, data_next;
    logic          par_bad_reg, par_bad_next;

    logic          stop_tick;
    logic          frame_ok;
    logic          frame_bad;

    logic [7:0]    ascii_reg;
    logic          dsn_reg;
    logic          clearn_reg;
    logic [CW-1:0] strobe_cnt_reg;
    logic          frame_err_reg;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_reg    <= 2'b11;
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            data_reg    <= '0;
            par_bad_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], rx};
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            data_reg    <= data_next;
            par_bad_reg <= par_bad_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CW'(1);
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        par_bad_next = par_bad_reg;
        case (state_reg)
            S_IDLE: begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                par_bad_next = 1'b0;
                if (!rx_s)
                    state_next = S_START;
            end
            S_START: begin
                // A start bit that is high again at its midpoint was only a glitch.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    data_next    = {rx_s, data_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_next = AFTER_DATA;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    par_bad_next = ^{data_reg, rx_s};
                    state_next   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                cnt_next = '0;
                if (rx_s)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        stop_tick = (state_reg == S_STOP) && (cnt_reg == BIT_LAST);
        frame_ok  = stop_tick && rx_s && !par_bad_reg;
        frame_bad = stop_tick && !rx_s;
    end

    // Strobe generator runs independently so a new frame can arrive mid-strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ascii_reg      <= 8'h00;
            dsn_reg        <= 1'b1;
            clearn_reg     <= 1'b1;
            strobe_cnt_reg <= '0;
            frame_err_reg  <= 1'b0;
        end else begin
            frame_err_reg <= frame_bad;
            if (frame_ok) begin
                strobe_cnt_reg <= STROBE_LAST;
                if (data_reg == CLEAR_CHAR) begin
                    clearn_reg <= 1'b0;
                    dsn_reg    <= 1'b1;
                end else begin
                    ascii_reg  <= data_reg;
                    dsn_reg    <= 1'b0;
                    clearn_reg <= 1'b1;
                end
            end else if (!dsn_reg || !clearn_reg) begin
                if (strobe_cnt_reg == '0) begin
                    dsn_reg    <= 1'b1;
                    clearn_reg <= 1'b1;
                end else begin
                    strobe_cnt_reg <= strobe_cnt_reg - CW'(1);
                end
            end
        end
    end

`ifdef UART_PARITY_EN
    logic parity_err_reg;

    always_ff @(posedge clk) begin
        if (!rstn)
            parity_err_reg <= 1'b0;
        else
            parity_err_reg <= (state_reg == S_PARITY) && (cnt_reg == BIT_LAST)
                              && (^{data_reg, rx_s});
    end

    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    assign ascii     = ascii_reg;
    assign dsn       = dsn_reg;
    assign clearn    = clearn_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != S_IDLE);

endmodule
